// File: rtl/adat_pkg.sv
// -----------------------------------------------------------------------------
// adat_pkg
// Shared types and constants for the ADAT frame path.
//   ADAT_CHANNELS   : channels per ADAT frame (fixed at 8)
//   ADAT_SAMPLE_W   : bits per audio sample (24)
//   ADAT_FRAME_CLKS : oversample clocks per ADAT frame (256)
//   adat_sample_t   : one signed 24-bit sample
//   adat_frame_t    : packed frame of eight samples, channel c at index c
//   adat_user_t     : user bits {timecode, midi, smux}
//   adat_seq_state_t: sequencer state (FILL collecting, FULL waiting for tick)
// -----------------------------------------------------------------------------
package adat_pkg;

  localparam int ADAT_CHANNELS   = 8;
  localparam int ADAT_SAMPLE_W   = 24;
  localparam int ADAT_FRAME_CLKS = 256;
  localparam int ADAT_CH_IDX_W   = $clog2(ADAT_CHANNELS);

  typedef logic signed [ADAT_SAMPLE_W-1:0] adat_sample_t;
  typedef adat_sample_t [ADAT_CHANNELS-1:0] adat_frame_t;
  typedef logic [2:0] adat_user_t;
  typedef logic [ADAT_CH_IDX_W-1:0] adat_ch_idx_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } adat_seq_state_t;

  // Index of the last channel in a frame; reaching it completes the frame.
  localparam adat_ch_idx_t ADAT_LAST_CH = adat_ch_idx_t'(ADAT_CHANNELS - 1);

  // Build a frame from the staged samples with one channel replaced by a
  // sample that is being accepted in the same cycle.
  function automatic adat_frame_t adat_bypass(input adat_frame_t  stage,
                                              input adat_ch_idx_t ch,
                                              input adat_sample_t smp);
    adat_frame_t f;
    f     = stage;
    f[ch] = smp;
    return f;
  endfunction

endpackage

// File: rtl/adat_frame_sequencer.sv
// -----------------------------------------------------------------------------
// adat_frame_sequencer
// Collects eight in-order samples from the mixer stream into a staging
// buffer and commits them, with the user bits, to the ADAT serializer inputs
// at every frame tick. An incomplete frame at the tick is muted and flagged as
// an underrun; out-of-order channels are flagged as sequence errors.
//
// Optional feature: define ADAT_UNDERRUN_COUNT_EN to add the saturating
// underrun_count output (width CNT_W).
//
// Ports
//   clk            : 256x oversample clock, single domain
//   reset          : asynchronous active-high reset
//   frame_tick     : one-cycle pulse per ADAT frame, ahead of serializer load
//   s_valid/s_ready: upstream handshake (s_ready is registered)
//   s_chan, s_data : channel index and signed sample of the offered word
//   user_in        : user bits sampled at frame_tick
//   audio_out      : committed frame, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   user_out       : committed user bits
//   underrun       : registered pulse, frame incomplete at tick
//   seq_error      : registered pulse, accepted channel not the expected one
//   underrun_count : saturating underrun counter (ADAT_UNDERRUN_COUNT_EN only)
// -----------------------------------------------------------------------------
module adat_frame_sequencer
  import adat_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SAMPLE_W = 24
`ifdef ADAT_UNDERRUN_COUNT_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [2:0]                   s_chan,
  input  logic [SAMPLE_W-1:0]          s_data,
  input  logic [2:0]                   user_in,
  output logic [CHANNELS*SAMPLE_W-1:0] audio_out,
  output logic [2:0]                   user_out,
  output logic                         underrun,
  output logic                         seq_error
`ifdef ADAT_UNDERRUN_COUNT_EN
  , output logic [CNT_W-1:0]           underrun_count
`endif
);

  // Registered state
  adat_seq_state_t state_q,     state_d;
  adat_ch_idx_t    next_ch_q,   next_ch_d;
  adat_frame_t     stage_q,     stage_d;
  adat_frame_t     audio_q,     audio_d;
  adat_user_t      user_q,      user_d;
  logic            s_ready_q,   s_ready_d;
  logic            underrun_q,  underrun_d;
  logic            seq_error_q, seq_error_d;

  // Decoded handshake conditions
  logic         accept_s;
  logic         in_order_s;
  logic         last_ch_s;
  adat_sample_t smp_s;
  adat_ch_idx_t chan_s;

  assign smp_s      = adat_sample_t'(s_data);
  assign chan_s     = adat_ch_idx_t'(s_chan);
  assign accept_s   = s_valid & s_ready_q;
  assign in_order_s = (chan_s == next_ch_q);
  // The completing accept: the expected channel is the last one and it arrives.
  assign last_ch_s  = accept_s & in_order_s & (next_ch_q == ADAT_LAST_CH);

  // Next-state and output decode for the fill/commit sequencer
  always_comb begin
    state_d     = state_q;
    next_ch_d   = next_ch_q;
    stage_d     = stage_q;
    audio_d     = audio_q;
    user_d      = user_q;
    underrun_d  = 1'b0;
    seq_error_d = 1'b0;

    case (state_q)
      FILL: begin
        if (frame_tick) begin
          // Tick always closes the frame and restarts collection at channel 0.
          user_d    = user_in;
          next_ch_d = '0;
          state_d   = FILL;
          if (last_ch_s) begin
            // Channel 7 lands on the tick cycle: still a complete frame,
            // bypass the incoming sample straight into the committed frame.
            audio_d = adat_bypass(stage_q, ADAT_LAST_CH, smp_s);
          end else begin
            // Partial frame: mute and flag; any sample accepted now is dropped.
            audio_d    = '0;
            underrun_d = 1'b1;
          end
          if (accept_s && !in_order_s) begin
            seq_error_d = 1'b1;
          end else begin
            seq_error_d = 1'b0;
          end
        end else if (accept_s) begin
          if (in_order_s) begin
            stage_d[next_ch_q] = smp_s;
            if (next_ch_q == ADAT_LAST_CH) begin
              state_d   = FULL;
              next_ch_d = '0;
            end else begin
              next_ch_d = next_ch_q + adat_ch_idx_t'(1);
            end
          end else begin
            seq_error_d = 1'b1;
            if (chan_s == adat_ch_idx_t'(0)) begin
              // A fresh channel 0 is a plausible restart: keep it and resync.
              stage_d[0] = smp_s;
              next_ch_d  = adat_ch_idx_t'(1);
            end else begin
              next_ch_d  = '0;
            end
          end
        end else begin
          state_d = FILL;
        end
      end

      FULL: begin
        if (frame_tick) begin
          audio_d   = stage_q;
          user_d    = user_in;
          next_ch_d = '0;
          state_d   = FILL;
        end else begin
          state_d = FULL;
        end
      end

      default: begin
        state_d   = FILL;
        next_ch_d = '0;
      end
    endcase

    // Ready is registered, so it tracks the state being entered.
    s_ready_d = (state_d == FILL);
  end

  // Sequencer state, staging buffer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      next_ch_q   <= '0;
      stage_q     <= '0;
      audio_q     <= '0;
      user_q      <= '0;
      s_ready_q   <= 1'b0;
      underrun_q  <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_ch_q   <= next_ch_d;
      stage_q     <= stage_d;
      audio_q     <= audio_d;
      user_q      <= user_d;
      s_ready_q   <= s_ready_d;
      underrun_q  <= underrun_d;
      seq_error_q <= seq_error_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign audio_out = audio_q;
  assign user_out  = user_q;
  assign underrun  = underrun_q;
  assign seq_error = seq_error_q;

`ifdef ADAT_UNDERRUN_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Count follows the registered underrun pulse, so it moves one cycle later.
  always_comb begin
    if (underrun_q && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Saturating underrun counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign underrun_count = count_q;
`endif

endmodule
